// File: rtl/fir_pkg.sv
// fir_pkg: shared register map, state encoding and reset values for the FIR engine
package fir_pkg;
  localparam logic [5:0] ADDR_CTRL   = 6'h20;
  localparam logic [5:0] ADDR_STATUS = 6'h21;
  localparam logic [5:0] ADDR_RESULT = 6'h22;
  localparam logic [5:0] ADDR_SAMPLE = 6'h23;
  localparam logic [5:0] ADDR_SHIFT  = 6'h24;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int CTRL_CLEAR = 15;
  localparam logic [4:0] NT_RST    = 5'h1F;
  localparam logic [4:0] SHIFT_RST = 5'h0F;
  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply, accumulator with clear/enable, shift and saturate to DW
module fir_mac #(
  parameter int DW   = 16,
  parameter int ACCW = 40
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] coef,
  input  logic signed [DW-1:0] samp,
  input  logic [4:0]           shift,
  output logic [DW-1:0]        y
);
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc, sh;
  logic fit;
  assign prod = coef * samp;
  assign sh   = acc >>> shift;
  // value fits in DW bits when all bits above the DW-1 sign position agree
  assign fit  = &sh[ACCW-1:DW-1] | ~|sh[ACCW-1:DW-1];
  assign y    = fit ? sh[DW-1:0] : {sh[ACCW-1], {(DW-1){~sh[ACCW-1]}}};
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
endmodule

// File: rtl/fir_core.sv
// fir_core: register-mapped tap-serial FIR engine with coefficient RAM and circular delay line
module fir_core
  import fir_pkg::*;
#(
  parameter int DW   = 16,
  parameter int ACCW = 40
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic [5:0]    p_address,
  input  logic [DW-1:0] p_data,
  input  logic          p_wr,
  output logic [DW-1:0] p_data_back,
  output logic          fir_done
);
  logic [DW-1:0] coef [32];
  logic [DW-1:0] dly [32];
  logic [DW-1:0] result, mac_y, rdata;
  logic [4:0] wp, wp_n, k, nt, shift;
  logic done, overrun;
  logic [2:0] status;
  fir_state_t state;
  logic wr_coef, wr_ctrl, wr_shift, wr_samp, clear, start;
  assign wr_coef  = p_wr & ~p_address[5];
  assign wr_ctrl  = p_wr & (p_address == ADDR_CTRL);
  assign wr_shift = p_wr & (p_address == ADDR_SHIFT);
  assign wr_samp  = p_wr & (p_address == ADDR_SAMPLE);
  assign clear    = wr_ctrl & p_data[CTRL_CLEAR];
  // OUT retires the result on the same edge, so a new sample may start there
  assign start    = wr_samp & (state != MAC) & ~clear;
  assign wp_n     = wp + 5'd1;
  assign status[ST_BUSY]    = state != IDLE;
  assign status[ST_DONE]    = done;
  assign status[ST_OVERRUN] = overrun;
  assign rdata = !p_address[5]               ? coef[p_address[4:0]] :
                 (p_address == ADDR_CTRL)    ? DW'(nt) :
                 (p_address == ADDR_STATUS)  ? DW'(status) :
                 (p_address == ADDR_RESULT)  ? result :
                 (p_address == ADDR_SHIFT)   ? DW'(shift) : '0;
  fir_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (start),
    .en      (state == MAC),
    .coef    (coef[k]),
    .samp    (dly[wp - k]),
    .shift   (shift),
    .y       (mac_y)
  );
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      for (int i = 0; i < 32; i++) begin
        coef[i] <= '0;
        dly[i]  <= '0;
      end
      result      <= '0;
      p_data_back <= '0;
      fir_done    <= 1'b0;
      wp          <= '0;
      k           <= '0;
      nt          <= NT_RST;
      shift       <= SHIFT_RST;
      done        <= 1'b0;
      overrun     <= 1'b0;
      state       <= IDLE;
    end else begin
      fir_done    <= 1'b0;
      p_data_back <= rdata;
      if (wr_coef) coef[p_address[4:0]] <= p_data;
      if (wr_shift) shift <= p_data[4:0];
      if (wr_ctrl) begin
        nt      <= p_data[4:0];
        overrun <= 1'b0;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) dly[i] <= '0;
        wp    <= '0;
        state <= IDLE;
      end else begin
        if (state == OUT) begin
          result   <= mac_y;
          done     <= 1'b1;
          fir_done <= 1'b1;
          state    <= IDLE;
        end
        if (state == MAC) begin
          k <= k + 5'd1;
          if (k == nt) state <= OUT;
          if (wr_samp) overrun <= 1'b1;
        end
        if (start) begin
          wp        <= wp_n;
          dly[wp_n] <= p_data;
          k         <= '0;
          done      <= 1'b0;
          state     <= MAC;
        end
      end
    end
endmodule

// File: tb/tb_fir_core.sv
// tb_fir_core: directed-vector self-checking bench for fir_core
module tb_fir_core;
  import fir_pkg::*;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic [5:0] p_address = '0;
  logic [15:0] p_data = '0;
  logic p_wr = 1'b0;
  logic [15:0] p_data_back;
  logic fir_done;
  int n_chk = 0;
  int n_err = 0;
  fir_core #(.DW(16), .ACCW(40)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .p_address   (p_address),
    .p_data      (p_data),
    .p_wr        (p_wr),
    .p_data_back (p_data_back),
    .fir_done    (fir_done)
  );
  always #5 PCLK = ~PCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask
  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    p_address = a;
    p_data    = d;
    p_wr      = 1'b1;
    tick();
    p_wr      = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [15:0] exp);
    p_address = a;
    tick();
    check(tag, p_data_back, exp);
  endtask
  task automatic run(input string tag, input logic [15:0] x, input int nt, input logic [15:0] exp);
    int busy = 0;
    int done_at = 0;
    int pulses = 0;
    wr(ADDR_SAMPLE, x);
    p_address = ADDR_STATUS;
    for (int i = 1; i <= nt + 6; i++) begin
      tick();
      if (p_data_back[ST_BUSY]) busy++;
      if (fir_done) begin
        pulses++;
        if (done_at == 0) done_at = i;
      end
    end
    check({tag, " busy"}, busy, nt + 2);
    check({tag, " done_at"}, done_at, nt + 2);
    check({tag, " pulses"}, pulses, 1);
    rd_chk({tag, " result"}, ADDR_RESULT, exp);
  endtask
  initial begin
    logic [15:0] imp_x [5] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] imp_y [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    int pulses;
    tick(2);
    check("rst data_back", p_data_back, 16'h0);
    check("rst fir_done", fir_done, 1'b0);
    PRESETn = 1'b1;
    tick();
    rd_chk("rst ctrl", ADDR_CTRL, 16'h001F);
    rd_chk("rst shift", ADDR_SHIFT, 16'h000F);
    rd_chk("rst status", ADDR_STATUS, 16'h0000);
    rd_chk("rst result", ADDR_RESULT, 16'h0000);
    rd_chk("rst unmapped", 6'h30, 16'h0000);
    // impulse response over four taps
    wr(ADDR_CTRL, 16'h0003);
    wr(ADDR_SHIFT, 16'h0000);
    for (int i = 0; i < 4; i++) wr(6'(i), 16'(i + 1));
    rd_chk("coef2 readback", 6'h02, 16'd3);
    for (int i = 0; i < 5; i++) run($sformatf("imp%0d", i), imp_x[i], 3, imp_y[i]);
    rd_chk("imp status", ADDR_STATUS, 16'h0002);
    // overrun: second sample lands two cycles into the run
    wr(ADDR_CTRL, 16'h8003);
    wr(ADDR_SAMPLE, 16'd5);
    tick();
    wr(ADDR_SAMPLE, 16'd7);
    tick(10);
    rd_chk("ovr status", ADDR_STATUS, 16'h0006);
    rd_chk("ovr result", ADDR_RESULT, 16'd5);
    wr(ADDR_CTRL, 16'h0003);
    rd_chk("ovr cleared", ADDR_STATUS, 16'h0002);
    // abort a 32-tap run with CLEAR
    wr(ADDR_CTRL, 16'h801F);
    wr(ADDR_SAMPLE, 16'd3);
    tick(2);
    wr(ADDR_CTRL, 16'h801F);
    p_address = ADDR_STATUS;
    pulses = 0;
    tick();
    if (fir_done) pulses++;
    check("abort status", p_data_back, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fir_done) pulses++;
    end
    check("abort no done", pulses, 0);
    rd_chk("abort result", ADDR_RESULT, 16'd5);
    run("abort_next", 16'd1, 31, 16'd1);
    // saturation at both rails
    for (int i = 0; i < 32; i++) wr(6'(i), 16'h7FFF);
    wr(ADDR_CTRL, 16'h801F);
    run("sat_pos", 16'h7FFF, 31, 16'h7FFF);
    wr(ADDR_CTRL, 16'h801F);
    run("sat_neg", 16'h8000, 31, 16'h8000);
    // asynchronous reset in the middle of MAC
    wr(ADDR_SAMPLE, 16'd9);
    p_address = ADDR_RESULT;
    tick(3);
    check("pre_rst data_back", p_data_back, 16'h8000);
    PRESETn = 1'b0;
    #1;
    check("mid_rst data_back", p_data_back, 16'h0);
    check("mid_rst fir_done", fir_done, 1'b0);
    tick();
    PRESETn = 1'b1;
    rd_chk("post_rst ctrl", ADDR_CTRL, 16'h001F);
    rd_chk("post_rst shift", ADDR_SHIFT, 16'h000F);
    rd_chk("post_rst status", ADDR_STATUS, 16'h0000);
    rd_chk("post_rst result", ADDR_RESULT, 16'h0000);
    rd_chk("post_rst coef0", 6'h00, 16'h0000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fir_core.md
# fir_core

Register-mapped FIR filter engine that sits directly downstream of the APB bridge. It consumes the bridge's internal peripheral bus: `p_address`, `p_data`, the `p_wr` pulse, and returns `p_data_back`. It holds a 32-entry coefficient RAM, a 32-sample circular delay line and control/status registers. Each sample write runs a tap-serial multiply-accumulate, one tap per clock, and produces a saturated 16-bit result.

## Interface
- `DW`, default 16: sample, coefficient and result width.
- `ACCW`, default 40: signed accumulator width; it must be at least 2*DW+5.
- `PCLK` in 1: the single clock; all logic is rising-edge.
- `PRESETn` in 1: reset, asynchronous and active-low.
- `p_address` in 6: register/RAM address, held stable by the bridge during an access.
- `p_data` in DW: write data.
- `p_wr` in 1: one-cycle write strobe.
- `p_data_back` out DW: registered read data for `p_address`.
- `fir_done` out 1: one-cycle pulse when a new result is written to RESULT.

## Operation
Address map:
- 0x00–0x1F COEF[i] (R/W): signed coefficient c[i].
- 0x20 CTRL (R/W):
  - [4:0] NT = taps−1.
  - [15] CLEAR: write-only, reads as 0.
  - Any CTRL write clears OVERRUN.
- 0x21 STATUS (RO): [0] BUSY, [1] DONE, [2] OVERRUN, others 0.
- 0x22 RESULT (RO): last saturated output.
- 0x23 SAMPLE (W, reads 0): writing x[n] starts a computation.
- 0x24 SHIFT (R/W): [4:0] arithmetic right shift applied to the accumulator.
- 0x25–0x3F: reads 0; writes ignored.

Reset values:
- `p_data_back` = 0, `fir_done` = 0.
- COEF, delay line, RESULT, STATUS = 0.
- CTRL = 0x001F (32 taps), SHIFT = 0x000F (Q15).
- Write pointer wp = 0, FSM in IDLE.

FSM states are IDLE, MAC and OUT.
- IDLE + SAMPLE write:
  - wp ← wp+1; delay[wp+1] ← sample.
  - acc ← 0, k ← 0, DONE ← 0, go to MAC.
- MAC, each cycle:
  - acc += c[k] × delay[(wp−k) mod 32]; products are signed DW×DW, sign-extended to ACCW.
  - If k == NT go to OUT, else k++.
- OUT:
  - RESULT ← sat_DW(acc >>> SHIFT), with saturation to [−2^(DW−1), 2^(DW−1)−1].
  - DONE ← 1, `fir_done` pulse, go to IDLE.
- BUSY = (state != IDLE).

Boundary conditions:
- SAMPLE write while BUSY: the sample is dropped, OVERRUN (sticky) is set, and the running computation is unaffected.
- CLEAR write:
  - Zeroes all 32 delay entries and sets wp ← 0 in one cycle.
  - If BUSY, it aborts to IDLE: no `fir_done`, DONE stays 0, RESULT unchanged.
  - The NT field of the same write is applied.
- COEF, CTRL.NT or SHIFT written while BUSY: the new value takes effect from the next cycle. The result is defined by the values used per cycle; the bench does not check it.
- Read-only or unmapped writes: no state change. The bridge flags the error; this block does not.
- Reads have no side effects; STATUS is not clear-on-read.
- Asynchronous reset mid-computation returns every register to its reset value immediately.

## Timing
- Read: `p_data_back` is registered each cycle from the current `p_address`, giving 1-cycle latency, well within the bridge's 6-cycle wait.
- Write: registers and RAM update on the edge that samples `p_wr` = 1.
- SAMPLE write sampled at edge E0:
  - BUSY = 1 after E0.
  - MAC occupies edges E1..E(NT+1).
  - RESULT, DONE and `fir_done` are valid after E(NT+2); BUSY = 0 after E(NT+2).
  - The next sample is accepted from edge E(NT+2) onward.
- Throughput: one sample per NT+2 cycles.

## Structure
- Package `fir_pkg` holds:
  - address constants: `ADDR_CTRL`, `ADDR_STATUS`, `ADDR_RESULT`, `ADDR_SAMPLE`, `ADDR_SHIFT`;
  - the state enum `fir_state_t` {IDLE, MAC, OUT};
  - STATUS bit indices;
  - reset constants for CTRL and SHIFT.
- Sub-module `fir_mac` holds the combinational multiply, the accumulator register with clear/enable, and the shift+saturate output stage.
- `fir_core` holds the register bank, RAMs, pointers and FSM.

## Test plan
- Reset, then read back: 0x20→0x001F, 0x24→0x000F, 0x21→0x0000, 0x22→0x0000, 0x30→0x0000.
- Impulse response:
  - Setup: CTRL=0x0003, SHIFT=0, COEF[0..3]=1,2,3,4.
  - Stimulus: samples 1,0,0,0,0.
  - Expected RESULT: 1,2,3,4,0.
  - Each computation: BUSY high exactly 5 cycles, `fir_done` one cycle after BUSY falls edge-wise at E5.
- Saturation:
  - Setup: all 32 COEF=0x7FFF, CTRL=0x001F, SHIFT=0.
  - Sample 0x7FFF gives RESULT=0x7FFF.
  - After CLEAR, sample 0x8000 gives RESULT=0x8000.
- Overrun:
  - Second SAMPLE write 2 cycles after the first.
  - STATUS=0x0006 after completion; RESULT equals the single-sample response.
  - A CTRL write then leaves STATUS=0x0002.
- Abort:
  - CLEAR written 3 cycles into a 32-tap run.
  - BUSY drops the next cycle, no `fir_done`, RESULT keeps its prior value.
  - The next impulse reproduces c[0].
- Reset mid-MAC: assert PRESETn low during MAC; all outputs are 0 and CTRL reads 0x001F afterwards.
